// File: rtl/bepu_bus_arbiter_pkg.sv
// rtl/bepu_bus_arbiter_pkg.sv - shared encodings and helpers for the FEPU->BEPU bus arbiter
package bepu_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  localparam int SEL_LSB_DEFAULT = 4;

  // 4-bit device index -> one-hot select; upper 16 bits can never be set
  function automatic logic [31:0] sel_decode(input logic [3:0] idx);
    return 32'h1 << idx;
  endfunction

endpackage

// File: rtl/bepu_bus_arbiter_rr_arb2.sv
// rtl/bepu_bus_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
module bepu_bus_arbiter_rr_arb2
  import bepu_bus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       winner,
  output logic       valid
);

  assign valid  = |req;
  // ptr only matters on a tie; a lone requester always wins
  assign winner = (&req) ? ptr : (req[1] ? OWNER_M1 : OWNER_M0);

endmodule

// File: rtl/bepu_bus_arbiter.sv
// rtl/bepu_bus_arbiter.sv - two-master round-robin arbiter for the FEPU->BEPU peripheral bus
module bepu_bus_arbiter
  import bepu_bus_arbiter_pkg::*;
#(
  parameter int SEL_LSB = SEL_LSB_DEFAULT,
  parameter int TIMEOUT = 16,
  parameter int TMR_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_w,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_w,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_sel,
  output logic        bus_w,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic              owner_q, owner_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [1:0][31:0]  rdata_q, rdata_d;
  logic [31:0]       bus_sel_q, bus_sel_d;
  logic              bus_w_q, bus_w_d;
  logic [31:0]       bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;

  logic              arb_winner;
  logic              arb_valid;
  logic              win_w;
  logic [31:0]       win_addr;
  logic [31:0]       win_wdata;

  bepu_bus_arbiter_rr_arb2 u_rr_arb2 (
    .req    ({m1_req, m0_req}),
    .ptr    (rr_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  assign win_w     = (arb_winner == OWNER_M1) ? m1_w     : m0_w;
  assign win_addr  = (arb_winner == OWNER_M1) ? m1_addr  : m0_addr;
  assign win_wdata = (arb_winner == OWNER_M1) ? m1_wdata : m0_wdata;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    err_d       = 2'b00;
    rdata_d     = '0;
    bus_sel_d   = bus_sel_q;
    bus_w_d     = bus_w_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        // bus fields are latched here so they are already valid during ADDR
        if (arb_valid) begin
          owner_d            = arb_winner;
          gnt_d[arb_winner]  = 1'b1;
          bus_sel_d          = sel_decode(win_addr[SEL_LSB +: 4]);
          bus_w_d            = win_w;
          bus_addr_d         = win_addr;
          bus_wdata_d        = win_wdata;
          state_d            = ST_ADDR;
        end
      end
      ST_ADDR: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus_ready || (timer_q == TMR_LAST)) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = ~bus_ready;
          if (bus_ready && !bus_w_q) begin
            rdata_d[owner_q] = bus_rdata;
          end
          bus_sel_d   = '0;
          bus_w_d     = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          state_d     = ST_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_RESP: begin
        rr_d    = ~owner_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= OWNER_M0;
      owner_q     <= OWNER_M0;
      timer_q     <= '0;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
      rdata_q     <= '0;
      bus_sel_q   <= '0;
      bus_w_q     <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      timer_q     <= timer_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      bus_sel_q   <= bus_sel_d;
      bus_w_q     <= bus_w_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];
  assign bus_sel   = bus_sel_q;
  assign bus_w     = bus_w_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule
